// File: rtl/pla_rd84_pkg.sv
// Shared types and sizing helpers for the frame popcount accumulator.
package pla_rd84_pkg;

  // Frame controller states.
  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Width of a single word weight (0..8 needs 4 bits).
  localparam int WEIGHT_W = 4;

  // Accumulator width large enough for 8*frame_len set bits.
  function automatic int calc_acc_w(input int frame_len);
    return $clog2(8 * frame_len + 1);
  endfunction

endpackage

// File: rtl/pla_rd84_popcount.sv
// Combinational set-bit counter for one 8-bit word.
module pla_rd84_popcount
  import pla_rd84_pkg::*;
(
  input  logic [7:0]          i_data,
  output logic [WEIGHT_W-1:0] o_weight
);

  // Sum the individual bits of the word.
  always_comb begin
    o_weight = '0;
    for (int i = 0; i < 8; i++) begin
      o_weight = o_weight + {{(WEIGHT_W-1){1'b0}}, i_data[i]};
    end
  end

endmodule

// File: rtl/pla_rd84_frame_acc.sv
// Frame accumulator: sums popcounts of FRAME_LEN accepted words and
// presents sum, max word weight and a threshold flag.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both 1. in_ready depends only on the state register; out_valid is
// held with stable data until out_ready is seen.
module pla_rd84_frame_acc
  import pla_rd84_pkg::*;
#(
  parameter  int FRAME_LEN = 16,
  parameter  int THRESH    = 64,
  localparam int ACC_W     = calc_acc_w(FRAME_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_sum,
  output logic [WEIGHT_W-1:0] out_max,
  output logic                out_over,
  output state_t              dbg_state
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_drain_wait;
  logic [WEIGHT_W-1:0] r_w1;
  logic                r_v1;
  logic [ACC_W-1:0]    r_acc;
  logic [WEIGHT_W-1:0] r_max_run;
  logic [ACC_W-1:0]    r_sum;
  logic [WEIGHT_W-1:0] r_max;
  logic                r_over;

  logic [WEIGHT_W-1:0] w_weight;
  logic                w_accept;
  logic                w_load;
  logic                w_clear;
  logic                w_over;

  pla_rd84_popcount u_popcount (
    .i_data   (in_data),
    .o_weight (w_weight)
  );

  assign w_over = (32'(r_acc) >= 32'(THRESH));

  // Next-state and handshake decode.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_accept  = 1'b0;
    w_load    = 1'b0;
    w_clear   = 1'b0;
    case (r_state)
      ACCUM: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (in_valid && (r_cnt == LAST_IDX)) w_next = DRAIN;
      end
      DRAIN: begin
        // Second DRAIN cycle: the last weight is already in r_acc.
        if (r_drain_wait) begin
          w_load = 1'b1;
          w_next = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_clear = 1'b1;
          w_next  = ACCUM;
        end
      end
      default: w_next = ACCUM;
    endcase
  end

  // State register and DRAIN sub-step flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ACCUM;
      r_drain_wait <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_drain_wait <= (r_state == DRAIN) && !r_drain_wait;
    end
  end

  // Word counter within the frame; holds at the last index until cleared.
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_cnt <= '0;
    end else if (w_accept && (r_cnt != LAST_IDX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Stage 1: register the weight of the accepted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w1 <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_w1 <= w_weight;
      r_v1 <= w_accept;
    end
  end

  // Stage 2: accumulate weight and track running maximum.
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_acc     <= '0;
      r_max_run <= '0;
    end else if (r_v1) begin
      r_acc <= r_acc + ACC_W'(r_w1);
      if (r_w1 > r_max_run) r_max_run <= r_w1;
    end
  end

  // Result registers, loaded once per frame and held through HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= '0;
      r_max  <= '0;
      r_over <= 1'b0;
    end else if (w_load) begin
      r_sum  <= r_acc;
      r_max  <= r_max_run;
      r_over <= w_over;
    end
  end

  assign out_sum   = r_sum;
  assign out_max   = r_max;
  assign out_over  = r_over;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pla_rd84_frame_acc.sv
// Directed bench for the frame accumulator (default and FRAME_LEN=2 builds).
module tb_pla_rd84_frame_acc;
  import pla_rd84_pkg::*;

  logic clk;
  logic rst;

  // Instance A: default parameters (FRAME_LEN=16, THRESH=64, ACC_W=8).
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_over;
  logic [7:0] a_in_data, a_out_sum;
  logic [3:0] a_out_max;
  state_t     a_dbg_state;

  // Instance B: FRAME_LEN=2, THRESH=9 (ACC_W=5).
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_over;
  logic [7:0] b_in_data;
  logic [4:0] b_out_sum;
  logic [3:0] b_out_max;
  state_t     b_dbg_state;

  int total;
  int bad;

  pla_rd84_frame_acc dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_out_sum), .out_max(a_out_max), .out_over(a_out_over),
    .dbg_state(a_dbg_state)
  );

  pla_rd84_frame_acc #(.FRAME_LEN(2), .THRESH(9)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_max(b_out_max), .out_over(b_out_over),
    .dbg_state(b_dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; all sampling/driving happens 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until accepted (bounded).
  task automatic send_word(input int sel, input logic [7:0] d);
    int n;
    logic rdy;
    n = 0;
    if (sel == 0) begin a_in_valid = 1'b1; a_in_data = d; end
    else          begin b_in_valid = 1'b1; b_in_data = d; end
    rdy = (sel == 0) ? a_in_ready : b_in_ready;
    while (!rdy && n < 50) begin
      tick();
      n++;
      rdy = (sel == 0) ? a_in_ready : b_in_ready;
    end
    if (!rdy) check("send_timeout", 32'(rdy), 32'd1);
    tick();
  endtask

  task automatic drop_valid(input int sel);
    if (sel == 0) a_in_valid = 1'b0;
    else          b_in_valid = 1'b0;
  endtask

  // Wait for out_valid (bounded); leaves time at a sample point.
  task automatic wait_out(input int sel);
    int n;
    logic v;
    n = 0;
    v = (sel == 0) ? a_out_valid : b_out_valid;
    while (!v && n < 50) begin
      tick();
      n++;
      v = (sel == 0) ? a_out_valid : b_out_valid;
    end
    check("wait_out", 32'(v), 32'd1);
  endtask

  task automatic check_a(input string tag, input logic [7:0] s, input logic [3:0] m, input logic o);
    check({tag, "_sum"},  32'(a_out_sum),  32'(s));
    check({tag, "_max"},  32'(a_out_max),  32'(m));
    check({tag, "_over"}, 32'(a_out_over), 32'(o));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state.
    check("rst_a_valid", 32'(a_out_valid), 32'd0);
    check("rst_a_ready", 32'(a_in_ready),  32'd1);
    check_a("rst_a", 8'd0, 4'd0, 1'b0);
    check("rst_a_state", 32'(a_dbg_state), 32'(ACCUM));
    check("rst_b_valid", 32'(b_out_valid), 32'd0);
    check("rst_b_sum",   32'(b_out_sum),   32'd0);

    // 16 x FF with latency check: valid after edge k+2.
    for (int i = 0; i < 16; i++) send_word(0, 8'hFF);
    drop_valid(0);
    check("lat_k1_valid", 32'(a_out_valid), 32'd0);
    check("lat_k1_ready", 32'(a_in_ready),  32'd0);
    tick();
    check("lat_k2_valid", 32'(a_out_valid), 32'd0);
    tick();
    check("lat_k3_valid", 32'(a_out_valid), 32'd1);
    check_a("ff", 8'd128, 4'd8, 1'b1);
    tick();
    check("ff_after_ready", 32'(a_in_ready),  32'd1);
    check("ff_after_valid", 32'(a_out_valid), 32'd0);

    // 16 x 01 with in_valid toggling; bubble carries junk data.
    for (int i = 0; i < 16; i++) begin
      send_word(0, 8'h01);
      drop_valid(0);
      a_in_data = 8'hFF;
      tick();
    end
    wait_out(0);
    check_a("bub", 8'd16, 4'd1, 1'b0);
    tick();

    // Mixed frame.
    send_word(0, 8'h00);
    send_word(0, 8'h0F);
    send_word(0, 8'hF0);
    send_word(0, 8'h7F);
    for (int i = 0; i < 12; i++) send_word(0, 8'h00);
    drop_valid(0);
    wait_out(0);
    check_a("mix", 8'd15, 4'd7, 1'b0);
    tick();

    // Backpressure in HOLD: 16 x AA = 64 (equality with THRESH).
    a_out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_word(0, 8'hAA);
    drop_valid(0);
    wait_out(0);
    check_a("hold0", 8'd64, 4'd4, 1'b1);
    a_in_valid = 1'b1;
    a_in_data  = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_ready", 32'(a_in_ready),  32'd0);
      check("hold_valid", 32'(a_out_valid), 32'd1);
      check("hold_state", 32'(a_dbg_state), 32'(HOLD));
      check_a("hold", 8'd64, 4'd4, 1'b1);
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    tick();
    check("release_ready", 32'(a_in_ready),  32'd1);
    check("release_valid", 32'(a_out_valid), 32'd0);

    // Reset while HOLD coincides with a handshake.
    a_out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_word(0, 8'h07);
    drop_valid(0);
    wait_out(0);
    check_a("pre_rst", 8'd48, 4'd3, 1'b0);
    rst = 1'b1;
    a_out_ready = 1'b1;
    tick();
    rst = 1'b0;
    check("hrst_valid", 32'(a_out_valid), 32'd0);
    check("hrst_ready", 32'(a_in_ready),  32'd1);
    check_a("hrst", 8'd0, 4'd0, 1'b0);

    // Reset mid-frame after 7 x FF, then 16 x 03.
    for (int i = 0; i < 7; i++) send_word(0, 8'hFF);
    drop_valid(0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_valid", 32'(a_out_valid), 32'd0);
    for (int i = 0; i < 16; i++) send_word(0, 8'h03);
    drop_valid(0);
    wait_out(0);
    check_a("mrst", 8'd32, 4'd2, 1'b0);
    tick();

    // FRAME_LEN=2, THRESH=9: equality boundary, then below threshold.
    send_word(1, 8'hFF);
    send_word(1, 8'h01);
    drop_valid(1);
    wait_out(1);
    check("b_sum",  32'(b_out_sum),  32'd9);
    check("b_max",  32'(b_out_max),  32'd8);
    check("b_over", 32'(b_out_over), 32'd1);
    tick();
    send_word(1, 8'h01);
    send_word(1, 8'h01);
    drop_valid(1);
    wait_out(1);
    check("b2_sum",  32'(b_out_sum),  32'd2);
    check("b2_max",  32'(b_out_max),  32'd1);
    check("b2_over", 32'(b_out_over), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
